// File: rtl/gv_input_pkg.sv
// Shared types and constants for the game input conditioning blocks.
package gv_input_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOCK_RISE,
    HIGH,
    LOCK_FALL
  } btn_state_t;

  typedef logic [2:0] mode_t;

  localparam logic [2:0] MODE_PLAY = 3'd4;

endpackage

// File: rtl/button_channel.sv
// One button channel: synchroniser, edge detect, and press/release lockout FSM.
module button_channel
  import gv_input_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned LOCKOUT_CYCLES = 800000
) (
  input  logic clk,
  input  logic n_rst,
  input  logic active_i,
  input  logic button_i,
  output logic posout_o,
  output logic negout_o,
  output logic held_o,
  output logic busy_o
);

  localparam int unsigned      CNT_W   = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(LOCKOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [SYNC_STAGES:0]   warm_q;
  btn_state_t             state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   posout_q;
  logic                   negout_q;
  logic                   held_q;
  logic                   busy_q;

  logic s;
  logic rise;
  logic cnt_done;

  assign s        = sync_q[SYNC_STAGES-1];
  // A button held through reset looks like a 0->1 step while the synchroniser
  // refills; warm_q hides rises until the chain holds only post-reset samples.
  assign rise     = s & ~prev_q & warm_q[SYNC_STAGES];
  assign cnt_done = (cnt_q == CntLast);

  // Synchroniser, previous-level flop and post-reset warm-up; independent of mode.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      warm_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], button_i};
      prev_q <= s;
      warm_q <= {warm_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // Lockout FSM with registered pulse, level and busy outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      posout_q <= 1'b0;
      negout_q <= 1'b0;
      held_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      posout_q <= 1'b0;
      negout_q <= 1'b0;
      if (!active_i) begin
        // Forced exit: silent, no release pulse.
        state_q <= IDLE;
        cnt_q   <= '0;
        held_q  <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (rise) begin
              posout_q <= 1'b1;
              held_q   <= 1'b1;
              busy_q   <= 1'b1;
              cnt_q    <= '0;
              state_q  <= LOCK_RISE;
            end
          end
          LOCK_RISE: begin
            if (cnt_done) begin
              cnt_q <= '0;
              if (s) begin
                busy_q  <= 1'b0;
                state_q <= HIGH;
              end else begin
                // Released during the lockout: report it straight away.
                negout_q <= 1'b1;
                held_q   <= 1'b0;
                state_q  <= LOCK_FALL;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          HIGH: begin
            if (!s) begin
              negout_q <= 1'b1;
              held_q   <= 1'b0;
              busy_q   <= 1'b1;
              cnt_q    <= '0;
              state_q  <= LOCK_FALL;
            end
          end
          LOCK_FALL: begin
            if (cnt_done) begin
              cnt_q   <= '0;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
            held_q  <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign posout_o = posout_q;
  assign negout_o = negout_q;
  assign held_o   = held_q;
  assign busy_o   = busy_q;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button conditioner: NUM_CH independent debounced channels,
// enabled only while the game is in ACTIVE_MODE.
module button_conditioner
  import gv_input_pkg::*;
#(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned LOCKOUT_CYCLES = 800000,
  parameter mode_t       ACTIVE_MODE    = MODE_PLAY
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [NUM_CH-1:0] button,
  input  mode_t             mode,
  output logic [NUM_CH-1:0] posout,
  output logic [NUM_CH-1:0] negout,
  output logic [NUM_CH-1:0] held,
  output logic [NUM_CH-1:0] busy
);

  logic active;

  // One mode decode shared by every channel.
  assign active = (mode == ACTIVE_MODE);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    button_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
    ) u_channel (
      .clk      (clk),
      .n_rst    (n_rst),
      .active_i (active),
      .button_i (button[g]),
      .posout_o (posout[g]),
      .negout_o (negout[g]),
      .held_o   (held[g]),
      .busy_o   (busy[g])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random presses, checked
// against a timestamp-based reference model of the debounce rules.
module tb_button_conditioner;

  localparam int NCH  = 4;
  localparam int LOCK = 8;
  localparam int HMAX = 8192;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [3:0] button;
  logic [2:0] mode;
  logic [3:0] posout, negout, held, busy;

  button_conditioner #(
    .NUM_CH         (NCH),
    .SYNC_STAGES    (2),
    .LOCKOUT_CYCLES (LOCK),
    .ACTIVE_MODE    (3'd4)
  ) dut (
    .clk    (clk),
    .n_rst  (n_rst),
    .button (button),
    .mode   (mode),
    .posout (posout),
    .negout (negout),
    .held   (held),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: sampled button history since reset, per-channel
  // debounced level and the edge index at which the current lockout expires.
  logic [3:0] hist [HMAX];
  int         k;
  int         lock_at [NCH];
  logic [3:0] lvl;
  logic [3:0] exp_pos, exp_neg, exp_held, exp_busy;
  int         pos_seen [NCH];
  int         neg_seen [NCH];
  int         any_seen;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s @%0t: observed %0h expected %0h", tag, $time, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    k   = 0;
    lvl = '0;
    for (int c = 0; c < NCH; c++) lock_at[c] = -1;
    exp_pos  = '0;
    exp_neg  = '0;
    exp_held = '0;
    exp_busy = '0;
  endtask

  // Applied at each rising edge with the inputs the DUT sampled there.
  task automatic model_edge();
    logic s, p, r, act;
    if (k >= HMAX) begin
      $display("FAIL model_depth: observed %0d expected <%0d", k, HMAX);
      $fatal(1);
    end
    hist[k] = button;
    act     = (mode == 3'd4);
    for (int c = 0; c < NCH; c++) begin
      s = (k >= 2) ? hist[k-2][c] : 1'b0;
      p = (k >= 3) ? hist[k-3][c] : 1'b0;
      r = s && !p && (k >= 3);
      exp_pos[c] = 1'b0;
      exp_neg[c] = 1'b0;
      if (!act) begin
        lvl[c]     = 1'b0;
        lock_at[c] = -1;
      end else if (!lvl[c]) begin
        // A press is only seen once the release lockout has fully elapsed.
        if (r && k > lock_at[c]) begin
          exp_pos[c] = 1'b1;
          lvl[c]     = 1'b1;
          lock_at[c] = k + LOCK;
        end
      end else if (k >= lock_at[c] && !s) begin
        exp_neg[c] = 1'b1;
        lvl[c]     = 1'b0;
        lock_at[c] = k + LOCK;
      end
      exp_held[c] = lvl[c];
      exp_busy[c] = act && (k < lock_at[c]);
    end
    k++;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_eq("posout", 16'(posout), 16'(exp_pos));
      check_eq("negout", 16'(negout), 16'(exp_neg));
      check_eq("held", 16'(held), 16'(exp_held));
      check_eq("busy", 16'(busy), 16'(exp_busy));
      check_eq("pos_neg_excl", 16'(posout & negout), 16'h0);
      for (int c = 0; c < NCH; c++) begin
        pos_seen[c] += int'(posout[c]);
        neg_seen[c] += int'(negout[c]);
      end
      if ((posout | negout | held | busy) != 4'h0) any_seen++;
    end
  endtask

  task automatic clear_seen();
    for (int c = 0; c < NCH; c++) begin
      pos_seen[c] = 0;
      neg_seen[c] = 0;
    end
    any_seen = 0;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    #1;
    model_reset();
    check_eq("rst_posout", 16'(posout), 16'(exp_pos));
    check_eq("rst_negout", 16'(negout), 16'(exp_neg));
    check_eq("rst_held", 16'(held), 16'(exp_held));
    check_eq("rst_busy", 16'(busy), 16'(exp_busy));
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  initial begin
    n_rst  = 1'b1;
    button = '0;
    mode   = 3'd4;
    clear_seen();
    #2;
    do_reset();
    step(6);

    // Single press and release on channel 0.
    clear_seen();
    button[0] = 1'b1;
    step(20);
    button[0] = 1'b0;
    step(24);
    check_eq("ch0_one_press", 16'(pos_seen[0]), 16'd1);
    check_eq("ch0_one_release", 16'(neg_seen[0]), 16'd1);

    // Bounce on channel 1, ending high (6 toggles) and ending low (5 toggles).
    for (int v = 6; v >= 5; v--) begin
      clear_seen();
      button[1] = 1'b1;
      for (int t = 0; t < v; t++) begin
        step(2);
        button[1] = ~button[1];
      end
      step(20);
      check_eq("bounce_one_press", 16'(pos_seen[1]), 16'd1);
      button[1] = 1'b0;
      step(24);
    end

    // Short tap on channel 2.
    button[2] = 1'b1;
    step(3);
    button[2] = 1'b0;
    step(30);

    // Mode drop while channel 3 is held, then return with the button still down.
    button[3] = 1'b1;
    step(20);
    clear_seen();
    mode = 3'd2;
    step(5);
    mode = 3'd4;
    step(12);
    check_eq("mode_exit_no_neg", 16'(neg_seen[3]), 16'd0);
    check_eq("mode_return_no_pos", 16'(pos_seen[3]), 16'd0);
    button[3] = 1'b0;
    step(20);
    clear_seen();
    button[3] = 1'b1;
    step(20);
    check_eq("repress_pos", 16'(pos_seen[3]), 16'd1);
    button[3] = 1'b0;
    step(24);

    // All channels together, then inactive mode with random activity.
    button = 4'hF;
    step(20);
    button = 4'h0;
    step(24);
    clear_seen();
    mode = 3'd1;
    for (int i = 0; i < 40; i++) begin
      button = 4'($urandom_range(0, 15));
      step(1);
    end
    check_eq("inactive_quiet", 16'(any_seen), 16'd0);
    button = 4'h0;
    mode   = 3'd4;
    step(12);

    // Reset in the middle of a press lockout, button kept held.
    button[0] = 1'b1;
    step(7);
    do_reset();
    clear_seen();
    step(20);
    check_eq("post_reset_no_pos", 16'(pos_seen[0]), 16'd0);
    button[0] = 1'b0;
    step(24);

    // Random presses with occasional mode changes.
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 7) == 0) button[c] = ~button[c];
      if ($urandom_range(0, 63) == 0)
        mode = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd4;
      step(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
